panel_uart_tx: RTL
==================

PANEL_UART_TX -- requirements
Module: panel_uart_tx

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 1000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 100, serial bit rate in bit/s; DIV = CLOCK_RATE/BAUD_RATE (integer, DIV >= 2, default 10).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  8  byte to transmit.
REQ-006 SHALL have port valid_in  input  1  data_in is valid this cycle.
REQ-007 SHALL have port ready_out  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port uart_data  output  1  serial line to the panel UART receiver, idle high, registered.
REQ-009 SHALL have port busy_out  output  1  frame in progress or FIFO non-empty.

Function
REQ-010 SHALL buffer bytes in a 4-entry FIFO; 2-bit read/write pointers wrap 3->0; 3-bit count 0..4.
REQ-011 SHALL accept a write on a rising edge only when valid_in=1 and ready_out=1.
REQ-012 SHALL drive ready_out = (count < 4), combinational from registered count only, never from valid_in or the same-cycle pop.
REQ-013 SHALL ignore valid_in while full: no pointer, count or data change.
REQ-014 SHALL keep count unchanged on simultaneous accepted push and pop; FIFO order preserved.
REQ-015 SHALL transmit 8N1 frames: start bit 0, data bits LSB first, one stop bit 1; no parity.
REQ-016 SHALL hold every bit for exactly DIV clock cycles, timed by a baud counter of width clog2(DIV) that reloads at each bit boundary; frame = 10*DIV cycles.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP with a 3-bit bit index in DATA.
REQ-018 IDLE: uart_data=1; if count>0, pop the head byte into a shift register, enter START, uart_data=0 from the same edge.
REQ-019 START -> DATA after DIV cycles; DATA shifts one bit per DIV cycles, -> STOP after bit index 7 completes.
REQ-020 STOP: uart_data=1 for DIV cycles; then, if count>0, pop and enter START on that same edge (no idle gap), else enter IDLE.
REQ-021 Latency: byte written at edge N into empty FIFO with FSM in IDLE SHALL produce uart_data=0 from edge N+1.
REQ-022 SHALL leave the transmitted byte unaffected by FIFO writes during the frame.
REQ-023 SHALL drive busy_out = (state != IDLE) or (count > 0), registered or combinational from registered state.

Reset
REQ-024 On reset=1 at a rising edge SHALL set: state=IDLE, uart_data=1, pointers=0, count=0, baud counter=0, bit index=0, shift register=0; hence ready_out=1, busy_out=0.
REQ-025 Reset mid-frame SHALL abort the frame: uart_data=1 from that edge, FIFO contents discarded, no partial frame resumes.
REQ-026 Reset SHALL take priority over a simultaneous write; the byte is discarded.

Verification (DIV=10)
REQ-027 Single byte: write 0xA5 at edge N -> uart_data low edges N+1..N+10, then bits 1,0,1,0,0,1,0,1 each 10 cycles, stop high 10 cycles, IDLE at N+101, busy_out low.
REQ-028 Back-to-back: write 0x00,0xFF,0x55 on consecutive edges -> three contiguous 100-cycle frames, no idle gap, bytes in order.
REQ-029 Overflow: write 6 bytes 0x01..0x06 on consecutive edges from idle -> first pops at once, 0x02..0x05 fill FIFO, ready_out=0 at 0x06, 0x06 dropped; line shows 0x01..0x05 only.
REQ-030 Push/pop collision: keep FIFO at count=2, write on the edge a STOP ends and pops -> count stays 2, no byte lost or duplicated.
REQ-031 Reset mid-frame: assert reset for 1 cycle during DATA bit 3 of 0x3C with 2 bytes queued -> uart_data=1 next edge, ready_out=1, busy_out=0, no further frames.
REQ-032 Random: 1000 random bytes with random valid_in gaps into a reference UART RX model sampling mid-bit -> all bytes received in order, no framing errors.

Source files
------------

// File: rtl/panel_uart_tx.sv
// panel_uart_tx: 4-entry byte FIFO feeding an 8N1 serial transmitter.
// The line is registered and idles high; frames run back-to-back while bytes are queued.
module panel_uart_tx #(
   parameter int CLOCK_RATE = 1000,
   parameter int BAUD_RATE  = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       uart_data,
   output logic       busy_out
);
   localparam int DIV = CLOCK_RATE / BAUD_RATE;
   localparam int BW = $clog2(DIV);
   localparam logic [BW-1:0] LAST = BW'(DIV - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state_q;
   logic [7:0]    mem_q [4];
   logic [1:0]    wr_q, rd_q;
   logic [2:0]    count_q, count_d;
   logic [BW-1:0] baud_q;
   logic [2:0]    idx_q;
   logic [7:0]    sh_q;
   logic          tick, push, pop;
   assign ready_out = count_q < 3'd4;
   assign tick = baud_q == LAST;
   assign push = valid_in & ready_out;
   // A byte leaves the FIFO either from idle or exactly as a stop bit ends.
   assign pop = (count_q != 3'd0) & ((state_q == IDLE) | ((state_q == STOP) & tick));
   assign count_d = count_q + {2'b00, push} - {2'b00, pop};
   assign busy_out = (state_q != IDLE) | (count_q != 3'd0);
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= data_in;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         uart_data <= 1'b1;
         wr_q      <= 2'd0;
         rd_q      <= 2'd0;
         count_q   <= 3'd0;
         baud_q    <= '0;
         idx_q     <= 3'd0;
         sh_q      <= 8'd0;
      end else begin
         count_q <= count_d;
         if (push) wr_q <= wr_q + 2'd1;
         if (pop) begin
            rd_q <= rd_q + 2'd1;
            sh_q <= mem_q[rd_q];
         end
         baud_q <= (state_q == IDLE || tick) ? '0 : baud_q + BW'(1);
         case (state_q)
            IDLE: if (pop) begin
               state_q   <= START;
               uart_data <= 1'b0;
            end
            START: if (tick) begin
               state_q   <= DATA;
               uart_data <= sh_q[0];
               sh_q      <= sh_q >> 1;
            end
            DATA: if (tick) begin
               idx_q     <= idx_q + 3'd1;
               state_q   <= (idx_q == 3'd7) ? STOP : DATA;
               uart_data <= (idx_q == 3'd7) | sh_q[0];
               sh_q      <= sh_q >> 1;
            end
            STOP: if (tick) begin
               state_q   <= pop ? START : IDLE;
               uart_data <= ~pop;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
